// File: rtl/micro_irq_controller.sv
// ---------------------------------------------------------------------------
// micro_irq_controller
//
// Interrupt aggregator for the micro. Source requests are latched into a
// pending register and masked by an enable register. The lowest-indexed
// active source is presented to the forth_micro core as one registered
// interrupt line plus a 4-bit vector. The core claims an interrupt by reading
// VECTOR and retires it by writing EOI. There is no nesting.
//
// Configuration macro:
//   MICRO_IRQ_EDGE_DETECT_EN  defined   : pending sets on a rising edge of irq_in
//                             undefined : pending sets on every cycle irq_in is high
//
// Parameters:
//   WIDTHD  data bus width (>= NIRQ+1)
//   NIRQ    number of sources, 1..16, index 0 = highest priority
//
// Ports:
//   clock           system clock
//   clock_areset_n  asynchronous active-low reset
//   address         register select (0 PENDING, 1 ENABLE, 2 VECTOR, 3 EOI/FORCE)
//   writedata       write data
//   readdata        registered read data, valid when waitrequest drops
//   read / write    slave strobes
//   waitrequest     stalls the first cycle of every read
//   irq_in          source requests
//   irq             interrupt request to core
//   irq_vector      index of the highest-priority active source
// ---------------------------------------------------------------------------
module micro_irq_controller #(
    parameter int WIDTHD = 32,
    parameter int NIRQ   = 8
) (
    input  logic              clock,
    input  logic              clock_areset_n,
    input  logic [3:0]        address,
    input  logic [WIDTHD-1:0] writedata,
    output logic [WIDTHD-1:0] readdata,
    input  logic              read,
    input  logic              write,
    output logic              waitrequest,
    input  logic [NIRQ-1:0]   irq_in,
    output logic              irq,
    output logic [3:0]        irq_vector
);

    typedef enum logic {
        IDLE       = 1'b0,
        IN_SERVICE = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [NIRQ-1:0]   pending_reg, pending_next;
    logic [NIRQ-1:0]   enable_reg, enable_next;
    logic [WIDTHD-1:0] readdata_reg, readdata_next;
    logic              read_latency_reg, read_latency_next;
    logic              irq_reg, irq_next;
    logic [3:0]        irq_vector_reg, irq_vector_next;
    logic [3:0]        svc_idx_reg, svc_idx_next;

    logic [NIRQ-1:0]   active;
    logic [NIRQ-1:0]   capture_set;
    logic [NIRQ-1:0]   force_set;
    logic [NIRQ-1:0]   w1c_clear;
    logic [NIRQ-1:0]   eoi_clear;
    logic [3:0]        prio_idx;
    logic              any_active;
    logic [WIDTHD-1:0] rd_mux;
    logic              rd_accept;
    logic              wr_pending;
    logic              wr_enable;
    logic              wr_eoi;
    logic              eoi_fire;
    logic              vec_claim;
    logic              unused_wdata;

    // Only a few writedata bits are decoded; fold the rest into a sink.
    assign unused_wdata = ^writedata;

    // Register contents are sampled on the first (stalled) cycle of a read.
    assign rd_accept   = read & ~read_latency_reg;
    assign waitrequest = write ? 1'b0 : (read ? ~read_latency_reg : 1'b0);

    assign wr_pending = write & (address == 4'h0);
    assign wr_enable  = write & (address == 4'h1);
    assign wr_eoi     = write & (address == 4'h3);

    assign active     = pending_reg & enable_reg;
    assign any_active = |active;

    // EOI only retires something while a source is in service.
    assign eoi_fire  = wr_eoi & writedata[0] & (state_reg == IN_SERVICE);
    // A VECTOR read that returns valid=1 claims the source when idle.
    assign vec_claim = rd_accept & (address == 4'h2) & any_active & (state_reg == IDLE);

`ifdef MICRO_IRQ_EDGE_DETECT_EN
    logic [NIRQ-1:0] irq_in_d_reg;

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            irq_in_d_reg <= '0;
        end else begin
            irq_in_d_reg <= irq_in;
        end
    end

    assign capture_set = irq_in & ~irq_in_d_reg;
`else
    assign capture_set = irq_in;
`endif

    // Per-source set/clear terms. Force bits live at [NIRQ+15:16]; any that
    // fall beyond the bus width simply cannot be forced.
    genvar gi;
    for (gi = 0; gi < NIRQ; gi++) begin : g_src
        if (16 + gi < WIDTHD) begin : g_force
            assign force_set[gi] = wr_eoi & writedata[16+gi];
        end else begin : g_no_force
            assign force_set[gi] = 1'b0;
        end
        assign w1c_clear[gi] = wr_pending & writedata[gi];
        assign eoi_clear[gi] = eoi_fire & (svc_idx_reg == 4'(gi));
    end

    // Lowest set index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        prio_idx = 4'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                prio_idx = 4'(i);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            4'h0: rd_mux[NIRQ-1:0] = pending_reg;
            4'h1: rd_mux[NIRQ-1:0] = enable_reg;
            4'h2: begin
                rd_mux[WIDTHD-1] = any_active;
                rd_mux[3:0]      = prio_idx;
            end
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        svc_idx_next = svc_idx_reg;
        case (state_reg)
            IDLE: begin
                if (vec_claim) begin
                    state_next   = IN_SERVICE;
                    svc_idx_next = prio_idx;
                end
            end
            IN_SERVICE: begin
                if (eoi_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Sets are applied after clears so a same-cycle set wins.
        pending_next      = (pending_reg & ~(w1c_clear | eoi_clear)) | capture_set | force_set;
        enable_next       = wr_enable ? writedata[NIRQ-1:0] : enable_reg;
        read_latency_next = read_latency_reg ? 1'b0 : read;
        readdata_next     = rd_accept ? rd_mux : readdata_reg;

        // Outputs follow the current state, so after EOI the retired source
        // never reappears for a stray cycle.
        if (state_reg == IDLE) begin
            irq_next        = any_active;
            irq_vector_next = prio_idx;
        end else begin
            irq_next        = 1'b0;
            irq_vector_next = svc_idx_reg;
        end
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            state_reg        <= IDLE;
            pending_reg      <= '0;
            enable_reg       <= '0;
            readdata_reg     <= '0;
            read_latency_reg <= 1'b0;
            irq_reg          <= 1'b0;
            irq_vector_reg   <= 4'd0;
            svc_idx_reg      <= 4'd0;
        end else begin
            state_reg        <= state_next;
            pending_reg      <= pending_next;
            enable_reg       <= enable_next;
            readdata_reg     <= readdata_next;
            read_latency_reg <= read_latency_next;
            irq_reg          <= irq_next;
            irq_vector_reg   <= irq_vector_next;
            svc_idx_reg      <= svc_idx_next;
        end
    end

    assign readdata   = readdata_reg;
    assign irq        = irq_reg;
    assign irq_vector = irq_vector_reg;

endmodule

// File: tb/tb_micro_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_micro_irq_controller
//
// Directed scenarios followed by randomized bus/source traffic. A
// transaction-level reference model (pending/enable bytes, an in-service
// flag and the serviced index) predicts every register read and the
// irq/irq_vector outputs once each transaction has settled.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_micro_irq_controller;

    localparam int WIDTHD = 32;
    localparam int NIRQ   = 8;

    logic              clock = 1'b0;
    logic              clock_areset_n = 1'b0;
    logic [3:0]        address = 4'd0;
    logic [WIDTHD-1:0] writedata = '0;
    logic [WIDTHD-1:0] readdata;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic              waitrequest;
    logic [NIRQ-1:0]   irq_in = '0;
    logic              irq;
    logic [3:0]        irq_vector;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    logic [7:0] m_pending = 8'h00;
    logic [7:0] m_enable  = 8'h00;
    bit         m_insvc   = 1'b0;
    int         m_svc     = 0;

    logic [31:0] rd;

    always #5 clock = ~clock;

    micro_irq_controller #(
        .WIDTHD(WIDTHD),
        .NIRQ  (NIRQ)
    ) dut (
        .clock         (clock),
        .clock_areset_n(clock_areset_n),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .read          (read),
        .write         (write),
        .waitrequest   (waitrequest),
        .irq_in        (irq_in),
        .irq           (irq),
        .irq_vector    (irq_vector)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Isolate the lowest set bit and take its position.
    function automatic int lowest(input logic [7:0] a);
        logic [7:0] iso;
        iso = a & (~a + 8'd1);
        return $clog2(iso);
    endfunction

    function automatic logic exp_irq();
        return !m_insvc && ((m_pending & m_enable) != 8'h00);
    endfunction

    function automatic logic [3:0] exp_vec();
        logic [7:0] act;
        act = m_pending & m_enable;
        if (m_insvc) return 4'(m_svc);
        if (act == 8'h00) return 4'd0;
        return 4'(lowest(act));
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        logic [31:0] r;
        logic [7:0]  act;
        r   = 32'h0;
        act = m_pending & m_enable;
        case (a)
            4'h0: r[7:0] = m_pending;
            4'h1: r[7:0] = m_enable;
            4'h2: if (act != 8'h00) begin
                r[31]  = 1'b1;
                r[3:0] = 4'(lowest(act));
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic settle();
        @(negedge clock);
        check("irq", {31'h0, irq}, {31'h0, exp_irq()});
        check("irq_vector", {28'h0, irq_vector}, {28'h0, exp_vec()});
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        #1;
        check("wr_waitrequest", {31'h0, waitrequest}, 32'h0);
        @(negedge clock);
        write     = 1'b0;
        writedata = '0;
        case (a)
            4'h0: m_pending = m_pending & ~d[7:0];
            4'h1: m_enable  = d[7:0];
            4'h3: begin
                if (d[0] && m_insvc) begin
                    m_pending[m_svc] = 1'b0;
                    m_insvc = 1'b0;
                end
                m_pending = m_pending | d[23:16];
            end
            default: ;
        endcase
`ifndef MICRO_IRQ_EDGE_DETECT_EN
        // a held level input re-sets its bit in the same cycle
        m_pending = m_pending | irq_in;
`endif
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        bus_write(a, d);
        settle();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        logic [31:0] exp;
        logic [7:0]  act;
        exp     = exp_read(a);
        act     = m_pending & m_enable;
        address = a;
        read    = 1'b1;
        #1;
        check("rd_wait_first", {31'h0, waitrequest}, 32'h1);
        @(negedge clock);
        check("rd_wait_second", {31'h0, waitrequest}, 32'h0);
        check($sformatf("rd_data@%0h", a), readdata, exp);
        d = readdata;
        @(negedge clock);
        read = 1'b0;
        if (a == 4'h2 && !m_insvc && act != 8'h00) begin
            m_insvc = 1'b1;
            m_svc   = lowest(act);
        end
    endtask

    // One-cycle source pulse; irq must not react until the cycle after pending.
    task automatic pulse(input logic [7:0] mask);
        logic old_irq;
        old_irq = exp_irq();
        irq_in  = mask;
        @(negedge clock);
        irq_in  = 8'h00;
        check("irq_latency", {31'h0, irq}, {31'h0, old_irq});
        m_pending = m_pending | mask;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #3;
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_vector", {28'h0, irq_vector}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_waitrequest", {31'h0, waitrequest}, 32'h0);
        @(negedge clock);
        clock_areset_n = 1'b1;
        bus_read(4'h0, rd);
        check("rst_pending", rd, 32'h0);

        // priority
        do_write(4'h1, 32'hFF);
        pulse(8'h24);
        settle();
        check("prio_irq", {31'h0, irq}, 32'h1);
        check("prio_vec", {28'h0, irq_vector}, 32'h2);
        bus_read(4'h2, rd);
        check("prio_vector_reg", rd, 32'h8000_0002);
        settle();
        check("svc_irq_low", {31'h0, irq}, 32'h0);

        // service and EOI
        do_write(4'h3, 32'h1);
        check("eoi_irq", {31'h0, irq}, 32'h1);
        check("eoi_vec", {28'h0, irq_vector}, 32'h5);
        bus_read(4'h0, rd);
        check("eoi_pending", rd, 32'h20);
        bus_read(4'h2, rd);
        check("svc5_vector_reg", rd, 32'h8000_0005);
        settle();
        do_write(4'h3, 32'h1);
        bus_read(4'h0, rd);
        check("eoi5_pending", rd, 32'h0);

        // EOI while idle changes nothing
        do_write(4'h1, 32'h0);
        pulse(8'h10);
        do_write(4'h3, 32'h1);
        bus_read(4'h0, rd);
        check("idle_eoi_pending", rd, 32'h10);
        do_write(4'h0, 32'h10);

        // mask
        pulse(8'h08);
        settle();
        bus_read(4'h0, rd);
        check("mask_pending", rd, 32'h08);
        check("mask_irq", {31'h0, irq}, 32'h0);
        do_write(4'h1, 32'h08);
        check("unmask_irq", {31'h0, irq}, 32'h1);
        check("unmask_vec", {28'h0, irq_vector}, 32'h3);
        do_write(4'h0, 32'h08);

        // set/clear collision with a held input
        do_write(4'h1, 32'h0);
        irq_in = 8'h02;
        @(negedge clock);
        m_pending = m_pending | 8'h02;
        bus_write(4'h0, 32'h02);
        settle();
        bus_read(4'h0, rd);
`ifdef MICRO_IRQ_EDGE_DETECT_EN
        check("collision_pending", rd, 32'h0);
`else
        check("collision_pending", rd, 32'h2);
`endif
        settle();
        settle();
        bus_read(4'h0, rd);
        irq_in = 8'h00;
        settle();
        do_write(4'h0, 32'h02);
        bus_read(4'h0, rd);
        check("collision_cleared", rd, 32'h0);

        // software force
        do_write(4'h1, 32'h01);
        do_write(4'h3, 32'h0001_0000);
        check("force_irq", {31'h0, irq}, 32'h1);
        check("force_vec", {28'h0, irq_vector}, 32'h0);
        bus_read(4'h0, rd);
        check("force_pending", rd, 32'h01);
        bus_read(4'h2, rd);
        check("force_vector_reg", rd, 32'h8000_0000);
        settle();
        do_write(4'h3, 32'h1);
        bus_read(4'h0, rd);
        check("force_eoi_pending", rd, 32'h0);
        check("force_eoi_irq", {31'h0, irq}, 32'h0);

        // reset mid-operation while in service
        do_write(4'h1, 32'hFF);
        pulse(8'h05);
        settle();
        bus_read(4'h2, rd);
        settle();
        #2;
        clock_areset_n = 1'b0;
        #1;
        check("midrst_irq", {31'h0, irq}, 32'h0);
        check("midrst_vec", {28'h0, irq_vector}, 32'h0);
        check("midrst_readdata", readdata, 32'h0);
        m_pending = 8'h00;
        m_enable  = 8'h00;
        m_insvc   = 1'b0;
        m_svc     = 0;
        @(negedge clock);
        clock_areset_n = 1'b1;
        bus_read(4'h0, rd);
        check("midrst_pending", rd, 32'h0);
        bus_read(4'h1, rd);
        check("midrst_enable", rd, 32'h0);
        do_write(4'h1, 32'h01);
        pulse(8'h01);
        settle();
        check("midrst_idle_irq", {31'h0, irq}, 32'h1);
        do_write(4'h0, 32'hFF);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] d;
            d = $urandom;
            case ($urandom_range(0, 7))
                0: begin
                    if ($urandom_range(0, 1) == 0) pulse(8'(1 << $urandom_range(0, 7)));
                    else pulse(8'($urandom_range(0, 255)));
                    settle();
                end
                1: do_write(4'h0, d);
                2: do_write(4'h1, d);
                3: begin bus_read(4'h2, rd); settle(); end
                4: begin
                    d = d & 32'hFF00_FFFF;
                    if ($urandom_range(0, 3) == 0) d = d | (32'h1 << (16 + $urandom_range(0, 7)));
                    do_write(4'h3, d);
                end
                5: begin bus_read(4'h0, rd); settle(); end
                6: begin bus_read(4'($urandom_range(1, 15)), rd); settle(); end
                default: do_write(4'($urandom_range(4, 15)), d);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
